// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch unit with execute-stage redirect
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [4:0]  ex_next_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_taken,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fetch_err
);

    localparam logic [4:0] PC_PLUS_4 = 5'b00000;
    localparam logic [4:0] PC_BRANCH = 5'b00100;
    localparam logic [4:0] PC_JALR   = 5'b00101;
    localparam logic [4:0] PC_JAL    = 5'b00110;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_inflight_pc;
    logic        r_kill;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc;
    logic        r_if_valid;
    logic        r_fetch_err;

    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_fault;
    logic        w_redir_ok;
    logic        w_code_plus4;

    // Decode the execute-stage redirect; every undefined code (and PC+4) is a no-op.
    always_comb begin
        w_redirect   = 1'b0;
        w_target     = ex_target;
        w_code_plus4 = (ex_next_pc == PC_PLUS_4);
        if (ex_valid) begin
            if (ex_next_pc == PC_JAL) begin
                w_redirect = 1'b1;
            end else if (ex_next_pc == PC_JALR) begin
                w_redirect = 1'b1;
                w_target   = {ex_target[31:1], 1'b0};
            end else if (ex_next_pc == PC_BRANCH) begin
                w_redirect = ex_taken;
            end
        end
        // A target that is still not word aligned after JALR masking is a fault
        w_fault    = w_redirect && (w_target[1:0] != 2'b00);
        w_redir_ok = w_redirect && (w_target[1:0] == 2'b00);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a misaligned redirect wins over everything and FAULT only exits via reset.
    always_comb begin
        w_state_next = r_state;
        if ((r_state != S_FAULT) && w_fault) begin
            w_state_next = S_FAULT;
        end else begin
            case (r_state)
                S_IDLE:  w_state_next = S_REQ;
                S_REQ:   w_state_next = imem_gnt ? S_WAIT : S_REQ;
                S_WAIT: begin
                    if (imem_rvalid) begin
                        w_state_next = (w_redir_ok || r_kill) ? S_REQ : S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_redir_ok || if_ready) begin
                        w_state_next = S_REQ;
                    end
                end
                S_FAULT: w_state_next = S_FAULT;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Outputs: request only while in REQ; everything else comes straight from registers.
    always_comb begin
        imem_req  = (r_state == S_REQ);
        imem_addr = r_pc;
        if_valid  = r_if_valid;
        if_instr  = r_if_instr;
        if_pc     = r_if_pc;
        fetch_err = r_fetch_err;
    end

    // Datapath: fetch address, in-flight tracking, kill flag and the decode-facing holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_inflight_pc <= 32'h0000_0000;
            r_kill        <= 1'b0;
            r_if_instr    <= NOP_INSTR;
            r_if_pc       <= 32'h0000_0000;
            r_if_valid    <= 1'b0;
            r_fetch_err   <= 1'b0;
        end else if (r_state != S_FAULT) begin
            if (w_fault) begin
                r_fetch_err <= 1'b1;
                r_if_valid  <= 1'b0;
            end else begin
                case (r_state)
                    S_REQ: begin
                        if (imem_gnt) begin
                            r_inflight_pc <= r_pc;
                            // The granted access is for the old address; drop its response
                            if (w_redir_ok) begin
                                r_kill <= 1'b1;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (imem_rvalid) begin
                            if (!w_redir_ok && !r_kill) begin
                                r_if_instr <= imem_rdata;
                                r_if_pc    <= r_inflight_pc;
                                r_pc       <= r_inflight_pc + 32'd4;
                                r_if_valid <= 1'b1;
                            end
                            r_kill <= 1'b0;
                        end else if (w_redir_ok) begin
                            r_kill <= 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (if_ready) begin
                            r_if_valid <= 1'b0;
                        end
                    end
                    default: begin
                        r_kill <= r_kill;
                    end
                endcase
                if (w_redir_ok) begin
                    r_pc       <= w_target;
                    r_if_valid <= 1'b0;
                end
            end
        end
    end

    // PC+4 needs no action beyond the default sequential flow
    logic w_unused;
    assign w_unused = w_code_plus4;

endmodule
